// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory / MMIO responder: region codes, MMIO
// register offsets, status bit positions and the address-region decoder.
package dmem_mmio_responder_pkg;

  // Address bits [31:28] select the target region.
  localparam logic [3:0] RegionCodeRam  = 4'h1;
  localparam logic [3:0] RegionCodeMmio = 4'h8;

  // MMIO register offsets (address bits [7:0]).
  localparam logic [7:0] OffStatus = 8'h00;
  localparam logic [7:0] OffRxData = 8'h04;
  localparam logic [7:0] OffTxData = 8'h08;
  localparam logic [7:0] OffCycle  = 8'h10;
  localparam logic [7:0] OffInstr  = 8'h14;
  localparam logic [7:0] OffCntClr = 8'h18;

  // Status register bit positions.
  localparam int unsigned StatusTxNotFull = 0;
  localparam int unsigned StatusRxFull    = 1;

  typedef enum logic [1:0] {
    RegionNone,
    RegionDram,
    RegionIo
  } region_e;

  function automatic region_e decode_region(input logic [3:0] code);
    region_e region;
    case (code)
      RegionCodeRam:  region = RegionDram;
      RegionCodeMmio: region = RegionIo;
      default:        region = RegionNone;
    endcase
    return region;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Small synchronous FIFO with occupancy count. Push into a full FIFO and pop
// from an empty one are ignored; fullness is judged on the registered count.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state pointers and count; Depth is a power of two so pointers wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CntOne;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Storage and pointer registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: byte-writable data RAM plus an MMIO block with a
// UART TX FIFO, UART RX holding register, and cycle / instruction counters.
// All reads return one cycle after the address, sampled before same-cycle updates.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int unsigned DMEM_AW  = 14,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_adr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  wea,
  input  logic        mem_re,
  input  logic        instr_stop,
  output logic [31:0] din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned DmemWords = 1 << DMEM_AW;
  localparam int unsigned TxCntW    = $clog2(TX_DEPTH) + 1;

  // Address decode
  region_e              region;
  logic [DMEM_AW-1:0]   word_idx;
  logic [7:0]           offset;
  logic                 is_store;
  logic                 io_sel;
  logic                 ram_we;

  assign region   = decode_region(mem_adr[31:28]);
  assign word_idx = mem_adr[DMEM_AW+1:2];
  assign offset   = mem_adr[7:0];
  assign is_store = |wea;
  assign io_sel   = (region == RegionIo);
  assign ram_we   = (region == RegionDram) & is_store;

  // MMIO side-effect strobes
  logic tx_push, cnt_clr, rx_clear, rx_capture, tx_pop;

  assign tx_push    = io_sel & is_store & (offset == OffTxData);
  assign cnt_clr    = io_sel & is_store & (offset == OffCntClr);
  // Only a real load drains the RX holding register.
  assign rx_clear   = io_sel & mem_re & (offset == OffRxData);
  assign rx_capture = rx_valid & rx_ready;
  assign tx_pop     = tx_valid & tx_ready;

  // Data RAM
  logic [31:0] ram_q [DmemWords];

  // Byte-masked RAM write; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wea[b]) begin
          ram_q[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // TX FIFO
  logic              tx_full, tx_empty;
  logic [TxCntW-1:0] tx_count;

  sync_fifo #(
    .Width (8),
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (tx_push),
    .wdata_i (mem_wdata[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  assign tx_valid = ~tx_empty;

  // RX holding register
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_buf_q, rx_buf_d;

  assign rx_ready = ~rx_full_q;

  // Capture only happens when empty, so it naturally outranks a clear.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_buf_d  = rx_buf_q;
    if (rx_capture) begin
      rx_full_d = 1'b1;
      rx_buf_d  = rx_data;
    end else if (rx_clear) begin
      rx_full_d = 1'b0;
    end
  end

  // RX state registers; reset discards any held byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_full_q <= 1'b0;
      rx_buf_q  <= '0;
    end else begin
      rx_full_q <= rx_full_d;
      rx_buf_q  <= rx_buf_d;
    end
  end

  // Counters
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] ins_cnt_q, ins_cnt_d;

  // Free-running increments wrap at 2^32; a clear store wins over increment.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q + 32'd1;
    ins_cnt_d = ins_cnt_q;
    if (!instr_stop) begin
      ins_cnt_d = ins_cnt_q + 32'd1;
    end
    if (cnt_clr) begin
      cyc_cnt_d = '0;
      ins_cnt_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      ins_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ins_cnt_q <= ins_cnt_d;
    end
  end

  // Read path
  logic [31:0] rd_data;

  // Read mux over pre-update state; unmapped and undefined offsets return 0.
  always_comb begin
    rd_data = '0;
    unique case (region)
      RegionDram: rd_data = ram_q[word_idx];
      RegionIo: begin
        case (offset)
          OffStatus: begin
            rd_data[StatusTxNotFull] = ~tx_full;
            rd_data[StatusRxFull]    = rx_full_q;
          end
          OffRxData: rd_data = {24'b0, rx_buf_q};
          OffCycle:  rd_data = cyc_cnt_q;
          OffInstr:  rd_data = ins_cnt_q;
          default:   rd_data = '0;
        endcase
      end
      default: rd_data = '0;
    endcase
  end

  // Registered read data for memory-stage alignment.
  always_ff @(posedge clk) begin
    if (reset) begin
      din <= '0;
    end else begin
      din <= rd_data;
    end
  end

  // Address bits above the RAM index are don't-care; occupancy is not needed here.
  logic unused_sigs;
  assign unused_sigs = ^{mem_adr[27:DMEM_AW+2], tx_count};

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_dmem_mmio_responder;

  localparam int unsigned DmemAw  = 14;
  localparam int unsigned TxDepth = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_adr, mem_wdata;
  logic [3:0]  wea;
  logic        mem_re, instr_stop;
  logic [31:0] din;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  always #5 clk = ~clk;

  dmem_mmio_responder #(
    .DMEM_AW  (DmemAw),
    .TX_DEPTH (TxDepth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .wea        (wea),
    .mem_re     (mem_re),
    .instr_stop (instr_stop),
    .din        (din),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] we,
                       input logic re);
    mem_adr   = adr;
    mem_wdata = wd;
    wea       = we;
    mem_re    = re;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic        re;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference model state
  logic [31:0] m_ram   [int];
  logic [3:0]  m_known [int];
  logic [7:0]  m_fifo  [$];
  logic        m_rx_full;
  logic [7:0]  m_rx_buf;
  logic [31:0] m_cyc, m_ins;

  function automatic logic [31:0] model_read(input logic [31:0] adr, output logic known);
    int idx;
    known = 1'b1;
    model_read = 32'h0;
    if (adr[31:28] == 4'h1) begin
      idx = int'(adr[DmemAw+1:2]);
      known = m_known.exists(idx) && (m_known[idx] == 4'hF);
      if (known) model_read = m_ram[idx];
    end else if (adr[31:28] == 4'h8) begin
      case (adr[7:0])
        8'h00: model_read = {30'b0, m_rx_full, (m_fifo.size() < TxDepth)};
        8'h04: model_read = {24'b0, m_rx_buf};
        8'h08: known = 1'b0;
        8'h10: model_read = m_cyc;
        8'h14: model_read = m_ins;
        default: model_read = 32'h0;
      endcase
    end
  endfunction

  task automatic model_step(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] we,
                            input logic re, input logic stop, input logic trdy,
                            input logic rvld, input logic [7:0] rdat);
    int  idx;
    bit  io, store, clr, pop, push;
    io    = (adr[31:28] == 4'h8);
    store = (we != 4'h0);
    if (adr[31:28] == 4'h1 && store) begin
      idx = int'(adr[DmemAw+1:2]);
      if (!m_known.exists(idx)) begin
        m_known[idx] = 4'h0;
        m_ram[idx]   = 32'h0;
      end
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          m_ram[idx][8*b +: 8] = wd[8*b +: 8];
          m_known[idx][b] = 1'b1;
        end
      end
    end
    clr   = io && store && (adr[7:0] == 8'h18);
    m_cyc = clr ? 32'h0 : m_cyc + 32'd1;
    m_ins = clr ? 32'h0 : (stop ? m_ins : m_ins + 32'd1);
    pop   = (m_fifo.size() > 0) && trdy;
    push  = io && store && (adr[7:0] == 8'h08) && (m_fifo.size() < TxDepth);
    if (pop) void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(wd[7:0]);
    if (rvld && !m_rx_full) begin
      m_rx_full = 1'b1;
      m_rx_buf  = rdat;
    end else if (io && re && (adr[7:0] == 8'h04)) begin
      m_rx_full = 1'b0;
    end
  endtask

  logic [31:0] rnd_adr [16] = '{
    32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C,
    32'h1000_0010, 32'h1FFF_0004, 32'h8000_0000, 32'h8000_0004,
    32'h8000_0008, 32'h8000_0008, 32'h8000_0008, 32'h8000_0010,
    32'h8000_0014, 32'h8000_0018, 32'h8000_000C, 32'h3000_0008
  };

  initial begin
    logic [7:0]  got [$];
    logic [31:0] exp_din;
    logic        known;
    logic [31:0] r_adr, r_wd;
    logic [3:0]  r_we;
    logic        r_re, r_stop, r_trdy, r_rvld;
    logic [7:0]  r_rdat;

    // Reset
    reset = 1'b1;
    idle();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h0;
    instr_stop = 1'b1;
    tick();
    tick();
    check("reset_din", din, 32'h0);
    check("reset_tx_valid", tx_valid, 32'h0);
    check("reset_tx_data", tx_data, 32'h0);
    check("reset_rx_ready", rx_ready, 32'h1);
    reset = 1'b0;

    // Single-cycle vector table
    vecs.push_back('{"ram_st_full",     32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"ram_st_lane1",    32'h1000_0010, 32'h0000_5500, 4'h2, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"ram_ld_merge",    32'h1000_0010, 32'h0,         4'h0, 1'b1, 1'b1, 32'hDEAD_55EF});
    vecs.push_back('{"ram_st2_full",    32'h1000_0014, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"ram_st2_lane0",   32'h1000_0014, 32'h0000_00AB, 4'h1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"ram_ld2_merge",   32'h1000_0014, 32'h0,         4'h0, 1'b1, 1'b1, 32'h1234_56AB});
    vecs.push_back('{"ram_alias_hi",    32'h1001_0010, 32'h0,         4'h0, 1'b1, 1'b1, 32'hDEAD_55EF});
    vecs.push_back('{"ram_byte_off",    32'h1000_0013, 32'h0,         4'h0, 1'b0, 1'b1, 32'hDEAD_55EF});
    vecs.push_back('{"unmapped_st",     32'h2000_0010, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{"ram_after_unmap", 32'h1000_0010, 32'h0,         4'h0, 1'b1, 1'b1, 32'hDEAD_55EF});
    vecs.push_back('{"status_idle",     32'h8000_0000, 32'h0,         4'h0, 1'b1, 1'b1, 32'h1});
    vecs.push_back('{"status_st_ign",   32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h1});
    vecs.push_back('{"status_again",    32'h8000_0000, 32'h0,         4'h0, 1'b0, 1'b1, 32'h1});
    vecs.push_back('{"undef_0c",        32'h8000_000C, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"undef_1c",        32'h8000_001C, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"unmapped_ld",     32'h2000_0000, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"unmapped_f_ld",   32'hF000_0010, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0});
    foreach (vecs[i]) begin
      drive(vecs[i].adr, vecs[i].wdata, vecs[i].wea, vecs[i].re);
      tick();
      if (vecs[i].chk) check(vecs[i].name, din, vecs[i].exp);
    end

    // TX FIFO: fill past capacity, then same-cycle push+pop on full
    idle();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(32'h8000_0008, 32'h41 + i, 4'hF, 1'b0);
      tick();
    end
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    check("tx_full_status", din, 32'h0);
    check("tx_full_valid", tx_valid, 32'h1);
    check("tx_full_head", tx_data, 32'h41);
    drive(32'h8000_0008, 32'h99, 4'hF, 1'b0);
    tx_ready = 1'b1;
    tick();
    idle();
    got.delete();
    for (int c = 0; c < 20 && tx_valid; c++) begin
      got.push_back(tx_data);
      tick();
    end
    check("tx_drain_count", got.size(), 32'd7);
    foreach (got[i]) check("tx_drain_byte", got[i], 32'h42 + i);
    check("tx_empty_after", tx_valid, 32'h0);
    tx_ready = 1'b0;
    drive(32'h8000_0008, 32'h55, 4'hF, 1'b0);
    tick();
    idle();
    check("tx_valid_rise", tx_valid, 32'h1);
    check("tx_single_head", tx_data, 32'h55);
    tx_ready = 1'b1;
    tick();
    check("tx_single_drained", tx_valid, 32'h0);
    tx_ready = 1'b0;

    // RX holding register
    rx_data = 8'h5A;
    rx_valid = 1'b1;
    tick();
    check("rx_ready_fall", rx_ready, 32'h0);
    rx_data = 8'h77;
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b0);
    tick();
    check("rx_status_full", din, 32'h3);
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
    tick();
    check("rx_peek_data", din, 32'h5A);
    check("rx_peek_keeps", rx_ready, 32'h0);
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b1);
    tick();
    check("rx_load_data", din, 32'h5A);
    check("rx_ready_rise", rx_ready, 32'h1);
    idle();
    tick();
    rx_valid = 1'b0;
    check("rx_recapture", rx_ready, 32'h0);
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
    tick();
    check("rx_second_byte", din, 32'h77);

    // Counters
    drive(32'h8000_0018, 32'h0, 4'hF, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 100; i++) begin
      instr_stop = (i < 30);
      tick();
    end
    instr_stop = 1'b1;
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    tick();
    check("cyc_after_100", din, 32'd100);
    drive(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    tick();
    check("ins_after_100", din, 32'd70);
    instr_stop = 1'b0;
    drive(32'h8000_0018, 32'h0, 4'h1, 1'b0);
    tick();
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    tick();
    check("cyc_cleared", din, 32'd0);
    drive(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    tick();
    check("ins_clr_prio", din, 32'd1);
    instr_stop = 1'b1;
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
    tick();
    check("cyc_preload", din, 32'hFFFF_FFFF);
    tick();
    check("cyc_wrap", din, 32'h0);

    // Reset mid-operation with FIFO and RX occupied
    for (int i = 0; i < 3; i++) begin
      drive(32'h8000_0008, 32'h10 + i, 4'hF, 1'b0);
      tick();
    end
    rx_data = 8'hC3;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("pre_rst_tx_valid", tx_valid, 32'h1);
    check("pre_rst_rx_ready", rx_ready, 32'h0);
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_din", din, 32'h0);
    check("rst_tx_valid", tx_valid, 32'h0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_rx_ready", rx_ready, 32'h1);
    reset = 1'b0;
    drive(32'h2000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    check("rst_unmapped_ld", din, 32'h0);
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    check("rst_status", din, 32'h1);

    // Randomized traffic against the reference model
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_fifo.delete();
    m_rx_full = 1'b0;
    m_rx_buf  = 8'h0;
    m_cyc     = 32'h0;
    m_ins     = 32'h0;
    for (int i = 0; i < 600; i++) begin
      r_adr  = rnd_adr[$urandom_range(0, 15)];
      r_wd   = $urandom;
      r_we   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      r_re   = 1'($urandom_range(0, 1));
      r_stop = 1'($urandom_range(0, 1));
      r_trdy = (i < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      r_rvld = ($urandom_range(0, 2) == 0);
      r_rdat = 8'($urandom);
      drive(r_adr, r_wd, r_we, r_re);
      instr_stop = r_stop;
      tx_ready   = r_trdy;
      rx_valid   = r_rvld;
      rx_data    = r_rdat;
      exp_din = model_read(r_adr, known);
      model_step(r_adr, r_wd, r_we, r_re, r_stop, r_trdy, r_rvld, r_rdat);
      tick();
      if (known) check("rnd_din", din, exp_din);
      check("rnd_tx_valid", tx_valid, 32'(m_fifo.size() != 0));
      check("rnd_rx_ready", rx_ready, 32'(!m_rx_full));
      if (m_fifo.size() != 0) check("rnd_tx_data", tx_data, 32'(m_fifo[0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
